timer_irq_ctrl: RTL and testbench
=================================

Name: timer_irq_ctrl

Overview:
- Receiving end of the timer pulse line: turns each 1-cycle timer pulse into a CPU interrupt request.
- Sits between the timer and the CPU core's interrupt input.
- Counts pulses not yet serviced, runs a request/acknowledge/end-of-interrupt handshake with the CPU, supplies the interrupt vector, and flags lost pulses.

Parameters:
- VECTOR_WIDTH, 8, width of the vector bus.
- TIMER_VECTOR, 8'h02, vector number driven on acknowledge.
- PEND_WIDTH, 4, width of the pending-pulse counter; maximum count is 2^PEND_WIDTH-1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- pulse  in  1  timer pulse; one cycle high per period.
- enable  in  1  interrupt enable from the CPU control register.
- inta  in  1  CPU interrupt acknowledge, 1 cycle.
- eoi  in  1  CPU end-of-interrupt, 1 cycle.
- overrun_clr  in  1  clears the overrun flag.
- irq  out  1  interrupt request to the CPU.
- vector  out  VECTOR_WIDTH  vector number; valid only while vector_valid=1.
- vector_valid  out  1  1-cycle strobe.
- pending_count  out  PEND_WIDTH  number of unserviced pulses.
- overrun  out  1  sticky flag: a pulse arrived while the counter was saturated.

Behaviour:
- Reset (asynchronous, active-high; clock is clock):
  - irq=0, vector=0, vector_valid=0, pending_count=0, overrun=0, state=IDLE.
  - Reset asserted mid-handshake aborts it immediately; a later inta or eoi from the CPU is ignored.
- Pending counter, updated every clock edge:
  - pulse && !dec: +1.
  - !pulse && dec: -1.
  - both together: count unchanged.
  - dec = inta accepted in REQUEST.
- Saturation:
  - pulse && !dec at max count: count holds and overrun<=1.
  - Overrun stays set until overrun_clr=1.
  - overrun_clr and a new overflow in the same cycle: set wins.
- FSM states are IDLE, REQUEST, SERVICE. All outputs are registered.
  - IDLE: if enable && pending_count!=0, go to REQUEST and set irq<=1.
    - Evaluates the registered count, so latency is pulse at edge N, count=1 after N+1, irq=1 after N+2.
  - REQUEST: irq holds at 1.
    - If inta: set irq<=0, vector<=TIMER_VECTOR, vector_valid<=1 for exactly one cycle, decrement the counter, go to SERVICE.
    - Else if !enable: set irq<=0 and go to IDLE; the counter is kept.
    - If inta and !enable arrive together, inta wins.
  - SERVICE: irq=0; pulses keep counting.
    - eoi: go to IDLE. If the count is still nonzero and enable=1, irq re-asserts 2 edges after eoi.
    - Changes to enable are ignored in this state.
- Stray strobes:
  - inta outside REQUEST: ignored.
  - eoi outside SERVICE: ignored.
- vector returns to 0 on the cycle after the strobe.
- No nesting: only one interrupt is in service at a time.

Optional Feature:
- Macro TIMER_IRQ_COALESCE_EN.
- Defined:
  - Pending state is a single bit, and pending_count reports 0 or 1 in bit 0 with upper bits 0.
  - An accepted inta clears the bit; a pulse in the same cycle as inta leaves it set.
  - A pulse while already pending sets overrun.
- Undefined: counting behaviour as above.

Decomposition:
- Package timer_irq_pkg holds:
  - state encoding constants (IDLE=2'd0, REQUEST=2'd1, SERVICE=2'd2);
  - the default TIMER_VECTOR value.
- One sub-module, irq_pend_counter: a saturating up/down counter with an overflow output, PEND_WIDTH parameter, and the coalesce variant selected by the macro.
- The FSM and output registers stay in the top module.

Test Plan:
- Basic handshake:
  - Stimulus: reset, enable=1, one pulse at cycle 10.
  - Response: pending_count=1 at 11, irq=1 at 12. inta at 15 gives irq=0, vector=8'h02, vector_valid=1 for one cycle, and count=0. eoi returns state to IDLE with no further irq.
- Back-to-back pulses:
  - Stimulus: 3 pulses, then service the first.
  - Response: count=3 then 2. After eoi, irq re-asserts 2 cycles later; it takes two more handshakes to reach count=0.
- Saturation:
  - Stimulus: enable=0, 16 pulses (PEND_WIDTH=4).
  - Response: count=15 and overrun=1. overrun_clr clears the flag while count stays 15.
- Simultaneous events:
  - Stimulus: pulse in the same cycle as inta with count=2.
  - Response: count stays 2; the vector strobe still fires.
- Enable drop and reset:
  - Stimulus: enable falls in REQUEST.
  - Response: irq=0 next cycle, count kept.
  - Stimulus: reset during SERVICE.
  - Response: all outputs 0; a following eoi has no effect.
- Coalesce build (TIMER_IRQ_COALESCE_EN defined):
  - Stimulus: 2 pulses before inta.
  - Response: pending_count=1 and overrun=1; after inta, pending_count=0.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// -----------------------------------------------------------------------------
// timer_irq_pkg
//   Shared definitions for the timer interrupt controller slice.
//   - irq_state_t          : handshake FSM state encoding (IDLE/REQUEST/SERVICE)
//   - DEFAULT_TIMER_VECTOR : vector number the controller presents on acknowledge
//   - is_ack()             : true when an acknowledge is actually accepted
// -----------------------------------------------------------------------------
package timer_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [7:0] DEFAULT_TIMER_VECTOR = 8'h02;

    // An acknowledge only counts while a request is outstanding; stray
    // inta pulses in any other state are dropped.
    function automatic logic is_ack(input irq_state_t state, input logic inta);
        return (state == REQUEST) && inta;
    endfunction

endpackage

// File: rtl/irq_pend_counter.sv
// -----------------------------------------------------------------------------
// irq_pend_counter
//   Saturating up/down counter of unserviced timer pulses.
//   Build option: TIMER_IRQ_COALESCE_EN -- when defined the pending state is a
//   single bit (count reads 0 or 1); otherwise a PEND_WIDTH-bit counter.
//
//   Ports:
//     clock    in   system clock, rising edge
//     reset    in   asynchronous, active-high
//     inc      in   one pulse arrived this cycle
//     dec      in   one pending pulse was taken into service this cycle
//     count    out  registered number of pending pulses
//     overflow out  combinational: a pulse is being dropped this cycle
// -----------------------------------------------------------------------------
module irq_pend_counter #(
    parameter int PEND_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    output logic [PEND_WIDTH-1:0] count,
    output logic                  overflow
);

`ifdef TIMER_IRQ_COALESCE_EN

    logic pending;

    // A pulse arriving together with the acknowledge re-arms the bit, so
    // set has priority over clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (inc) begin
            pending <= 1'b1;
        end else if (dec) begin
            pending <= 1'b0;
        end
    end

    assign overflow = inc && !dec && pending;

    always_comb begin
        count    = '0;
        count[0] = pending;
    end

`else

    localparam logic [PEND_WIDTH-1:0] MAX_COUNT = '1;

    logic [PEND_WIDTH-1:0] cnt;

    assign overflow = inc && !dec && (cnt == MAX_COUNT);

    // inc and dec together cancel; the zero guard on dec is defensive since
    // an accepted acknowledge always has at least one pulse behind it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != MAX_COUNT)) begin
            cnt <= cnt + 1'b1;
        end else if (!inc && dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign count = cnt;

`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_irq_ctrl
//   Turns 1-cycle timer pulses into a CPU interrupt request, runs the
//   request / acknowledge / end-of-interrupt handshake, supplies the vector
//   and flags pulses lost to saturation.
//   Build option: TIMER_IRQ_COALESCE_EN (single-bit pending state, see
//   irq_pend_counter).
//
//   Ports:
//     clock          in   system clock, rising edge
//     reset          in   asynchronous, active-high
//     pulse          in   timer pulse, one cycle high per period
//     enable         in   interrupt enable from the CPU control register
//     inta           in   CPU interrupt acknowledge, 1 cycle
//     eoi            in   CPU end-of-interrupt, 1 cycle
//     overrun_clr    in   clears the overrun flag
//     irq            out  interrupt request to the CPU
//     vector         out  vector number, valid only with vector_valid
//     vector_valid   out  1-cycle strobe accompanying vector
//     pending_count  out  number of unserviced pulses
//     overrun        out  sticky: a pulse arrived while pending was saturated
//
//   Handshake: irq rises when a pulse is pending and enable=1. The CPU answers
//   with a 1-cycle inta while irq=1; that cycle irq drops, vector/vector_valid
//   strobe for exactly one cycle and one pending pulse is consumed. The CPU
//   then finishes with a 1-cycle eoi; only after eoi can irq rise again.
//   inta outside a request and eoi outside service are ignored. Dropping
//   enable while requesting withdraws irq and keeps the pulse pending.
//
//   The FSM state is held in the internal signal `state` for observation.
// -----------------------------------------------------------------------------
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int                      VECTOR_WIDTH = 8,
    parameter logic [VECTOR_WIDTH-1:0] TIMER_VECTOR = VECTOR_WIDTH'(DEFAULT_TIMER_VECTOR),
    parameter int                      PEND_WIDTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pulse,
    input  logic                    enable,
    input  logic                    inta,
    input  logic                    eoi,
    input  logic                    overrun_clr,
    output logic                    irq,
    output logic [VECTOR_WIDTH-1:0] vector,
    output logic                    vector_valid,
    output logic [PEND_WIDTH-1:0]   pending_count,
    output logic                    overrun
);

    irq_state_t state;
    logic       dec;
    logic       overflow;

    assign dec = is_ack(state, inta);

    irq_pend_counter #(
        .PEND_WIDTH (PEND_WIDTH)
    ) u_pend (
        .clock    (clock),
        .reset    (reset),
        .inc      (pulse),
        .dec      (dec),
        .count    (pending_count),
        .overflow (overflow)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            irq          <= 1'b0;
            vector       <= '0;
            vector_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // Vector is a strobe: it returns to zero unless re-loaded below.
            vector_valid <= 1'b0;
            vector       <= '0;

            // A fresh overflow beats a clear in the same cycle.
            if (overflow) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                // Looks at the registered count, which adds one cycle of
                // latency from pulse to irq.
                IDLE: begin
                    if (enable && (pending_count != '0)) begin
                        state <= REQUEST;
                        irq   <= 1'b1;
                    end
                end
                // inta has priority over a simultaneous enable drop.
                REQUEST: begin
                    if (inta) begin
                        state        <= SERVICE;
                        irq          <= 1'b0;
                        vector       <= TIMER_VECTOR;
                        vector_valid <= 1'b1;
                    end else if (!enable) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                // enable is deliberately ignored until the CPU signals eoi.
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_ctrl
//   Directed scenarios plus a randomized run against a cycle-level reference
//   model of the controller's rules.
// -----------------------------------------------------------------------------
module tb_timer_irq_ctrl;

`ifdef TIMER_IRQ_COALESCE_EN
    localparam int PMAX = 1;
`else
    localparam int PMAX = 15;
`endif

    localparam int PH_WAITING   = 0;
    localparam int PH_REQUESTED = 1;
    localparam int PH_IN_SVC    = 2;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pulse = 1'b0;
    logic       enable = 1'b0;
    logic       inta = 1'b0;
    logic       eoi = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       irq;
    logic [7:0] vector;
    logic       vector_valid;
    logic [3:0] pending_count;
    logic       overrun;

    always #5 clock = ~clock;

    timer_irq_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .pulse         (pulse),
        .enable        (enable),
        .inta          (inta),
        .eoi           (eoi),
        .overrun_clr   (overrun_clr),
        .irq           (irq),
        .vector        (vector),
        .vector_valid  (vector_valid),
        .pending_count (pending_count),
        .overrun       (overrun)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int         m_cnt;
    bit         m_ovr;
    int         m_phase;
    bit         m_irq;
    bit         m_vv;
    logic [7:0] m_vec;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_cnt = 0; m_ovr = 0; m_phase = PH_WAITING; m_irq = 0; m_vv = 0; m_vec = 8'h00;
    endtask

    // Next-cycle outputs from current state and the inputs seen at the edge.
    task automatic model_step(input bit p, input bit en, input bit ia, input bit eo, input bit clr);
        bit ack;
        int old_cnt;
        old_cnt = m_cnt;
        ack     = (m_phase == PH_REQUESTED) && ia;
        if (p && !ack && m_cnt == PMAX) begin
            m_ovr = 1;
        end else begin
            if (clr) m_ovr = 0;
            m_cnt = m_cnt + (p ? 1 : 0) - (ack ? 1 : 0);
        end
        m_vv  = ack;
        m_vec = ack ? 8'h02 : 8'h00;
        if (ack) exp_q.push_back(8'h02);
        if (m_phase == PH_WAITING) begin
            if (en && old_cnt != 0) begin m_phase = PH_REQUESTED; m_irq = 1; end
        end else if (m_phase == PH_REQUESTED) begin
            if (ack) begin m_phase = PH_IN_SVC; m_irq = 0; end
            else if (!en) begin m_phase = PH_WAITING; m_irq = 0; end
        end else begin
            if (eo) m_phase = PH_WAITING;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        pulse = 0; enable = 0; inta = 0; eoi = 0; overrun_clr = 0;
        reset = 1;
        cyc();
        reset = 0;
        model_reset();
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 20) begin cyc(); n++; end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL %s_irq_timeout got=%0b exp=1", tag, irq); end
    endtask

    task automatic ack_and_eoi();
        inta = 1; cyc(); inta = 0;
        cyc();
        eoi = 1; cyc(); eoi = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        total++; if (vector !== 8'h00) begin bad++; $display("FAIL reset_vector got=%0h exp=00", vector); end
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL reset_vv got=%0b exp=0", vector_valid); end
        total++; if (pending_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_basic();
        do_reset();
        enable = 1;
        repeat (9) cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_idle_irq got=%0b exp=0", irq); end
        pulse = 1; cyc(); pulse = 0;
        total++; if (pending_count !== 4'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", pending_count); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_latency got=%0b exp=0", irq); end
        cyc();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_up got=%0b exp=1", irq); end
        repeat (2) cyc();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_hold got=%0b exp=1", irq); end
        inta = 1; cyc(); inta = 0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_ack_irq got=%0b exp=0", irq); end
        total++; if (vector !== 8'h02) begin bad++; $display("FAIL basic_vector got=%0h exp=02", vector); end
        total++; if (vector_valid !== 1'b1) begin bad++; $display("FAIL basic_vv got=%0b exp=1", vector_valid); end
        total++; if (pending_count !== 4'd0) begin bad++; $display("FAIL basic_count0 got=%0d exp=0", pending_count); end
        cyc();
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL basic_vv_drop got=%0b exp=0", vector_valid); end
        total++; if (vector !== 8'h00) begin bad++; $display("FAIL basic_vector_drop got=%0h exp=00", vector); end
        eoi = 1; cyc(); eoi = 0;
        repeat (5) cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_no_reirq got=%0b exp=0", irq); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1;
        pulse = 1; repeat (3) cyc(); pulse = 0;
        total++; if (pending_count !== 4'd3) begin bad++; $display("FAIL b2b_count3 got=%0d exp=3", pending_count); end
        wait_irq("b2b_first");
        inta = 1; cyc(); inta = 0;
        total++; if (pending_count !== 4'd2) begin bad++; $display("FAIL b2b_count2 got=%0d exp=2", pending_count); end
        total++; if (vector_valid !== 1'b1) begin bad++; $display("FAIL b2b_vv got=%0b exp=1", vector_valid); end
        cyc();
        eoi = 1; cyc(); eoi = 0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL b2b_eoi_edge_irq got=%0b exp=0", irq); end
        cyc();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL b2b_reirq got=%0b exp=1", irq); end
        for (int k = 0; k < 2; k++) begin
            wait_irq("b2b_loop");
            ack_and_eoi();
        end
        repeat (4) cyc();
        total++; if (pending_count !== 4'd0) begin bad++; $display("FAIL b2b_final_count got=%0d exp=0", pending_count); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL b2b_final_irq got=%0b exp=0", irq); end
    endtask

    task automatic test_saturation();
        do_reset();
        enable = 0;
        pulse = 1; repeat (15) cyc();
        total++; if (pending_count !== 4'd15) begin bad++; $display("FAIL sat_count15 got=%0d exp=15", pending_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL sat_no_ovr_yet got=%0b exp=0", overrun); end
        cyc(); pulse = 0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL sat_overrun got=%0b exp=1", overrun); end
        total++; if (pending_count !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", pending_count); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL sat_irq_disabled got=%0b exp=0", irq); end
        overrun_clr = 1; cyc(); overrun_clr = 0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL sat_clear got=%0b exp=0", overrun); end
        total++; if (pending_count !== 4'd15) begin bad++; $display("FAIL sat_clear_count got=%0d exp=15", pending_count); end
        pulse = 1; overrun_clr = 1; cyc(); pulse = 0; overrun_clr = 0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL sat_set_wins got=%0b exp=1", overrun); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        enable = 1;
        pulse = 1; repeat (2) cyc(); pulse = 0;
        wait_irq("simul");
        total++; if (pending_count !== 4'd2) begin bad++; $display("FAIL simul_pre_count got=%0d exp=2", pending_count); end
        pulse = 1; inta = 1; cyc(); pulse = 0; inta = 0;
        total++; if (pending_count !== 4'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", pending_count); end
        total++; if (vector_valid !== 1'b1) begin bad++; $display("FAIL simul_vv got=%0b exp=1", vector_valid); end
        total++; if (vector !== 8'h02) begin bad++; $display("FAIL simul_vector got=%0h exp=02", vector); end
        eoi = 1; cyc(); eoi = 0;
    endtask

    task automatic test_enable_drop_reset();
        do_reset();
        enable = 1;
        pulse = 1; cyc(); pulse = 0;
        wait_irq("edrop");
        enable = 0; cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL edrop_irq got=%0b exp=0", irq); end
        total++; if (pending_count !== 4'd1) begin bad++; $display("FAIL edrop_count got=%0d exp=1", pending_count); end
        inta = 1; cyc(); inta = 0;
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL stray_inta_vv got=%0b exp=0", vector_valid); end
        total++; if (pending_count !== 4'd1) begin bad++; $display("FAIL stray_inta_count got=%0d exp=1", pending_count); end
        enable = 1; cyc();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL edrop_reirq got=%0b exp=1", irq); end
        inta = 1; cyc(); inta = 0;
        pulse = 1; cyc(); pulse = 0;
        #2 reset = 1;
        #1;
        total++; if (irq !== 1'b0 || vector !== 8'h00 || vector_valid !== 1'b0)
            begin bad++; $display("FAIL rst_svc_out got=%0b/%0h/%0b exp=0/00/0", irq, vector, vector_valid); end
        total++; if (pending_count !== 4'd0 || overrun !== 1'b0)
            begin bad++; $display("FAIL rst_svc_cnt got=%0d/%0b exp=0/0", pending_count, overrun); end
        #1 reset = 0;
        model_reset();
        eoi = 1; cyc(); eoi = 0;
        repeat (3) cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_eoi_irq got=%0b exp=0", irq); end
        total++; if (pending_count !== 4'd0) begin bad++; $display("FAIL rst_eoi_count got=%0d exp=0", pending_count); end
    endtask

    task automatic test_coalesce();
        do_reset();
        enable = 1;
        pulse = 1; repeat (2) cyc(); pulse = 0;
        total++; if (pending_count !== 4'd1) begin bad++; $display("FAIL coal_count got=%0d exp=1", pending_count); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL coal_overrun got=%0b exp=1", overrun); end
        wait_irq("coal");
        inta = 1; cyc(); inta = 0;
        total++; if (pending_count !== 4'd0) begin bad++; $display("FAIL coal_after_ack got=%0d exp=0", pending_count); end
        total++; if (vector_valid !== 1'b1) begin bad++; $display("FAIL coal_vv got=%0b exp=1", vector_valid); end
        eoi = 1; cyc(); eoi = 0;
    endtask

    task automatic test_random();
        bit         en_r;
        logic [7:0] got;
        do_reset();
        exp_q.delete();
        en_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) en_r = !en_r;
            enable      = en_r;
            pulse       = ($urandom_range(0, 3) == 0);
            inta        = ($urandom_range(0, 2) == 0);
            eoi         = ($urandom_range(0, 2) == 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            model_step(pulse, enable, inta, eoi, overrun_clr);
            cyc();
            total++; if (irq !== m_irq) begin bad++; $display("FAIL rand_irq i=%0d got=%0b exp=%0b", i, irq, m_irq); end
            total++; if (vector_valid !== m_vv) begin bad++; $display("FAIL rand_vv i=%0d got=%0b exp=%0b", i, vector_valid, m_vv); end
            total++; if (vector !== m_vec) begin bad++; $display("FAIL rand_vector i=%0d got=%0h exp=%0h", i, vector, m_vec); end
            total++; if (pending_count !== 4'(m_cnt)) begin bad++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, pending_count, m_cnt); end
            total++; if (overrun !== m_ovr) begin bad++; $display("FAIL rand_overrun i=%0d got=%0b exp=%0b", i, overrun, m_ovr); end
            if (vector_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_sb_extra i=%0d got=%0h exp=none", i, vector);
                end else begin
                    got = exp_q.pop_front();
                    if (vector !== got) begin bad++; $display("FAIL rand_sb_vector i=%0d got=%0h exp=%0h", i, vector, got); end
                end
            end
        end
        pulse = 0; inta = 0; eoi = 0; overrun_clr = 0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_sb_missing got=%0d exp=0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
`ifdef TIMER_IRQ_COALESCE_EN
        test_coalesce();
`else
        test_basic();
        test_back_to_back();
        test_saturation();
        test_simultaneous();
`endif
        test_enable_drop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
